// File: rtl/anton_neopixel_frame_scheduler_pkg.sv
// Shared definitions for the NeoPixel frame scheduler: state encodings and
// default parameter values.
package anton_neopixel_frame_scheduler_pkg;

  localparam int SCHED_PERIOD_WIDTH_DEFAULT = 24;
  localparam int SCHED_TIMEOUT_DEFAULT      = 64;
  localparam int SCHED_COUNT_WIDTH_DEFAULT  = 16;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_START       = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY   = 3'd2;
  localparam logic [2:0] ST_STREAM      = 3'd3;
  localparam logic [2:0] ST_WAIT_PERIOD = 3'd4;

  typedef enum logic [2:0] {
    IDLE        = ST_IDLE,
    START       = ST_START,
    WAIT_BUSY   = ST_WAIT_BUSY,
    STREAM      = ST_STREAM,
    WAIT_PERIOD = ST_WAIT_PERIOD
  } sched_state_t;

endpackage

// File: rtl/anton_sched_period_counter.sv
// Saturating up-counter with synchronous clear. The reached output is high
// once the count is at least max(limit,1)-1, so a limit of 0 acts as 1.
// Used for both the refresh period and the busy-rise timeout.
module anton_sched_period_counter
  import anton_neopixel_frame_scheduler_pkg::*;
#(
  parameter int WIDTH = SCHED_PERIOD_WIDTH_DEFAULT
) (
  input  logic             clk6_4mhz,
  input  logic             apbPresern,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             reached
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] threshold;

  // Count up every cycle, hold at all-ones, restart from zero on clear.
  always_ff @(posedge clk6_4mhz or negedge apbPresern) begin
    if (!apbPresern) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + WIDTH'(1);
    end
  end

  assign threshold = (limit == '0) ? '0 : limit - WIDTH'(1);
  assign reached   = (count >= threshold);

endmodule

// File: rtl/anton_neopixel_frame_scheduler.sv
// NeoPixel frame scheduler: issues syncStart one-shot or periodically, follows
// streamBusy to frame completion, and reports frames and timeouts.
// Optional build macro: ANTON_NEOPIXEL_SCHED_OVERRUN_EN adds the overrunCount
// output (saturating count of frames that ran past their refresh period).
module anton_neopixel_frame_scheduler
  import anton_neopixel_frame_scheduler_pkg::*;
#(
  parameter int PERIOD_WIDTH = SCHED_PERIOD_WIDTH_DEFAULT,
  parameter int TIMEOUT      = SCHED_TIMEOUT_DEFAULT,
  parameter int COUNT_WIDTH  = SCHED_COUNT_WIDTH_DEFAULT
) (
  input  logic                    clk6_4mhz,
  input  logic                    apbPresern,
  input  logic                    enable,
  input  logic                    continuous,
  input  logic                    trigger,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    streamBusy,
  input  logic                    errClear,
  output logic                    syncStart,
  output logic                    frameDone,
  output logic [COUNT_WIDTH-1:0]  frameCount,
  output logic                    timeoutErr,
`ifdef ANTON_NEOPIXEL_SCHED_OVERRUN_EN
  output logic [7:0]              overrunCount,
`endif
  output logic                    schedBusy
);

  localparam int TIMEOUT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT);

  sched_state_t state, next_state;
  logic pending;
  logic period_hit;
  logic timeout_hit;
  logic counters_clear;
  logic frame_end;
  logic timeout_set;

  assign counters_clear = (state == START);
  assign frame_end      = (state == STREAM) && !streamBusy;
  // Busy rising wins over a timeout landing in the same cycle.
  assign timeout_set    = (state == WAIT_BUSY) && !streamBusy && timeout_hit;

  anton_sched_period_counter #(
    .WIDTH (PERIOD_WIDTH)
  ) u_period_counter (
    .clk6_4mhz  (clk6_4mhz),
    .apbPresern (apbPresern),
    .clear      (counters_clear),
    .limit      (period),
    .reached    (period_hit)
  );

  anton_sched_period_counter #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timeout_counter (
    .clk6_4mhz  (clk6_4mhz),
    .apbPresern (apbPresern),
    .clear      (counters_clear),
    .limit      (TIMEOUT_LIMIT),
    .reached    (timeout_hit)
  );

  // State register.
  always_ff @(posedge clk6_4mhz or negedge apbPresern) begin
    if (!apbPresern) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (enable && (pending || trigger || continuous)) begin
          next_state = START;
        end
      end
      START: begin
        next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (streamBusy) begin
          next_state = STREAM;
        end else if (timeout_hit) begin
          next_state = IDLE;
        end
      end
      STREAM: begin
        if (!streamBusy) begin
          next_state = (enable && continuous) ? WAIT_PERIOD : IDLE;
        end
      end
      WAIT_PERIOD: begin
        if (!enable || !continuous) begin
          next_state = pending ? START : IDLE;
        end else if (period_hit) begin
          next_state = START;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // One-deep trigger queue; the request being served is consumed on entry to START.
  always_ff @(posedge clk6_4mhz or negedge apbPresern) begin
    if (!apbPresern) begin
      pending <= 1'b0;
    end else if (next_state == START) begin
      pending <= 1'b0;
    end else if (trigger) begin
      pending <= 1'b1;
    end
  end

  // Registered outputs; syncStart and schedBusy follow the state being entered.
  always_ff @(posedge clk6_4mhz or negedge apbPresern) begin
    if (!apbPresern) begin
      syncStart  <= 1'b0;
      schedBusy  <= 1'b0;
      frameDone  <= 1'b0;
      frameCount <= '0;
      timeoutErr <= 1'b0;
    end else begin
      syncStart  <= (next_state == START);
      schedBusy  <= (next_state != IDLE);
      frameDone  <= frame_end;
      if (frame_end) begin
        frameCount <= frameCount + COUNT_WIDTH'(1);
      end
      timeoutErr <= timeout_set || (timeoutErr && !errClear);
    end
  end

`ifdef ANTON_NEOPIXEL_SCHED_OVERRUN_EN
  logic overrun_seen;
  logic overrun_now;

  assign overrun_now = overrun_seen ||
                       (((state == WAIT_BUSY) || (state == STREAM)) && period_hit);

  // Track whether the current frame outlived its period; count it when the frame hands over to WAIT_PERIOD.
  always_ff @(posedge clk6_4mhz or negedge apbPresern) begin
    if (!apbPresern) begin
      overrun_seen <= 1'b0;
      overrunCount <= 8'd0;
    end else begin
      overrun_seen <= (state == START) ? 1'b0 : overrun_now;
      if (errClear) begin
        overrunCount <= 8'd0;
      end else if (frame_end && (next_state == WAIT_PERIOD) && overrun_now &&
                   (overrunCount != 8'hFF)) begin
        overrunCount <= overrunCount + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_anton_neopixel_frame_scheduler.sv
// Self-checking bench for anton_neopixel_frame_scheduler. A behavioural
// transmitter answers each syncStart after a programmable delay with a busy
// burst; frame timing is predicted with plain arithmetic from the scheduling rules.
module tb_anton_neopixel_frame_scheduler;

  localparam int PW = 24;
  localparam int TO = 64;
  localparam int CW = 16;

  logic          clk6_4mhz = 1'b0;
  logic          apbPresern;
  logic          enable;
  logic          continuous;
  logic          trigger;
  logic [PW-1:0] period;
  logic          streamBusy;
  logic          errClear;
  logic          syncStart;
  logic          frameDone;
  logic [CW-1:0] frameCount;
  logic          timeoutErr;
  logic          schedBusy;
`ifdef ANTON_NEOPIXEL_SCHED_OVERRUN_EN
  logic [7:0]    overrunCount;
  int            exp_overrun = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_count = 0;
  int sync_q[$];
  int done_q[$];
  int xmit_delay = 0;
  int xmit_len   = 1;
  bit xmit_en     = 1'b1;
  bit xmit_active = 1'b0;

  anton_neopixel_frame_scheduler #(
    .PERIOD_WIDTH (PW),
    .TIMEOUT      (TO),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk6_4mhz    (clk6_4mhz),
    .apbPresern   (apbPresern),
    .enable       (enable),
    .continuous   (continuous),
    .trigger      (trigger),
    .period       (period),
    .streamBusy   (streamBusy),
    .errClear     (errClear),
    .syncStart    (syncStart),
    .frameDone    (frameDone),
    .frameCount   (frameCount),
    .timeoutErr   (timeoutErr),
`ifdef ANTON_NEOPIXEL_SCHED_OVERRUN_EN
    .overrunCount (overrunCount),
`endif
    .schedBusy    (schedBusy)
  );

  always #5 clk6_4mhz = ~clk6_4mhz;

  always @(posedge clk6_4mhz) cyc <= cyc + 1;

  // Event log: cycle numbers of every syncStart and frameDone pulse.
  always @(negedge clk6_4mhz) begin
    if (syncStart === 1'b1) sync_q.push_back(cyc);
    if (frameDone === 1'b1) done_q.push_back(cyc);
  end

  // Transmitter model: busy high for xmit_len cycles starting xmit_delay+1 cycles after syncStart.
  initial begin
    streamBusy = 1'b0;
    forever begin
      @(negedge clk6_4mhz);
      if (xmit_en && syncStart === 1'b1) begin
        xmit_active = 1'b1;
        repeat (xmit_delay + 1) @(posedge clk6_4mhz);
        #1 streamBusy = 1'b1;
        repeat (xmit_len) @(posedge clk6_4mhz);
        #1 streamBusy = 1'b0;
        xmit_active = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Spacing between consecutive syncStarts in periodic mode.
  function automatic int model_spacing(int p, int d, int l);
    int pe;
    int frame;
    pe    = (p == 0) ? 1 : p;
    frame = d + l + 2;
    return ((pe > frame) ? pe : frame) + 1;
  endfunction

`ifdef ANTON_NEOPIXEL_SCHED_OVERRUN_EN
  function automatic bit model_overrun(int p, int d, int l);
    int pe;
    pe = (p == 0) ? 1 : p;
    return (d + l) >= (pe - 1);
  endfunction
`endif

  task automatic tick(int n);
    repeat (n) @(posedge clk6_4mhz);
    #1;
  endtask

  task automatic pulse_trigger(output int t);
    trigger = 1'b1;
    t = cyc;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic pulse_clear();
    errClear = 1'b1;
    tick(1);
    errClear = 1'b0;
  endtask

  task automatic wait_idle(output bit expired);
    int w = 0;
    int quiet = 0;
    while (quiet < 4 && w < 3000) begin
      tick(1);
      w++;
      if (schedBusy === 1'b0 && !xmit_active) quiet++;
      else quiet = 0;
    end
    expired = (quiet < 4);
  endtask

  task automatic run_frames(input int p, input int d, input int l, input int n,
                            output int t0, output bit expired);
    int w = 0;
    bit e2;
    period     = PW'(p);
    xmit_delay = d;
    xmit_len   = l;
    sync_q.delete();
    done_q.delete();
    continuous = 1'b1;
    t0 = cyc;
    while (sync_q.size() < n && w < 3000) begin
      tick(1);
      w++;
    end
    continuous = 1'b0;
    wait_idle(e2);
    expired = (w >= 3000) || e2;
  endtask

  task automatic test_reset();
    apbPresern = 1'b0;
    enable = 1'b0; continuous = 1'b0; trigger = 1'b0;
    errClear = 1'b0; period = '0;
    tick(3);
    n_checks++;
    if ({syncStart, frameDone, timeoutErr, schedBusy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags_during: got %b expected 0000", {syncStart, frameDone, timeoutErr, schedBusy});
    end
    n_checks++;
    if (frameCount !== '0) begin
      n_fail++;
      $display("FAIL reset_count_during: got %0d expected 0", frameCount);
    end
    apbPresern = 1'b1;
    tick(3);
    n_checks++;
    if ({syncStart, frameDone, timeoutErr, schedBusy} !== 4'b0000 || frameCount !== '0) begin
      n_fail++;
      $display("FAIL reset_after_release: got flags %b count %0d expected 0000 / 0",
               {syncStart, frameDone, timeoutErr, schedBusy}, frameCount);
    end
  endtask

  task automatic test_one_shot();
    int t;
    bit expired;
    enable = 1'b1; continuous = 1'b0; period = PW'(100);
    xmit_delay = 1; xmit_len = 28;
    sync_q.delete(); done_q.delete();
    pulse_trigger(t);
    wait_idle(expired);
    exp_count++;
    n_checks++;
    if (expired) begin n_fail++; $display("FAIL one_shot_wait: got timeout expected idle"); end
    n_checks++;
    if (sync_q.size() !== 1 || (sync_q.size() > 0 && sync_q[0] !== t + 1)) begin
      n_fail++;
      $display("FAIL one_shot_sync: got %0d pulses first at %0d expected 1 at %0d",
               sync_q.size(), (sync_q.size() > 0) ? sync_q[0] - t : -1, 1);
    end
    n_checks++;
    if (done_q.size() !== 1 || (done_q.size() > 0 && done_q[0] !== t + 32)) begin
      n_fail++;
      $display("FAIL one_shot_done: got %0d pulses first at +%0d expected 1 at +32",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - t : -1);
    end
    n_checks++;
    if (frameCount !== CW'(exp_count)) begin
      n_fail++;
      $display("FAIL one_shot_count: got %0d expected %0d", frameCount, exp_count);
    end
  endtask

  task automatic test_pending_disabled();
    int t;
    int te;
    bit expired;
    enable = 1'b0; continuous = 1'b0;
    xmit_delay = 0; xmit_len = 5;
    sync_q.delete(); done_q.delete();
    pulse_trigger(t);
    tick(5);
    n_checks++;
    if (sync_q.size() !== 0 || schedBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_disabled_hold: got %0d pulses busy %b expected 0 / 0", sync_q.size(), schedBusy);
    end
    enable = 1'b1;
    te = cyc;
    wait_idle(expired);
    exp_count++;
    n_checks++;
    if (expired || sync_q.size() !== 1 || (sync_q.size() > 0 && sync_q[0] !== te + 1)) begin
      n_fail++;
      $display("FAIL pending_served: got %0d pulses first at +%0d expected 1 at +1",
               sync_q.size(), (sync_q.size() > 0) ? sync_q[0] - te : -1);
    end
    n_checks++;
    if (frameCount !== CW'(exp_count)) begin
      n_fail++;
      $display("FAIL pending_count: got %0d expected %0d", frameCount, exp_count);
    end
  endtask

  task automatic test_continuous();
    int p, d, l, n, t0, sp;
    bit expired;
    enable = 1'b1; xmit_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        p = 100; d = 0; l = 30; n = 5;
      end else begin
        p = $urandom_range(0, 60);
        d = $urandom_range(0, 4);
        l = $urandom_range(1, 40);
        n = $urandom_range(2, 4);
      end
      pulse_clear();
      run_frames(p, d, l, n, t0, expired);
      sp = model_spacing(p, d, l);
      exp_count += n;
      n_checks++;
      if (expired) begin n_fail++; $display("FAIL cont_wait case %0d: got timeout expected idle", k); end
      n_checks++;
      if (sync_q.size() !== n || done_q.size() !== n) begin
        n_fail++;
        $display("FAIL cont_pulses case %0d: got sync %0d done %0d expected %0d", k, sync_q.size(), done_q.size(), n);
      end
      n_checks++;
      if (sync_q.size() == 0 || sync_q[0] !== t0 + 1) begin
        n_fail++;
        $display("FAIL cont_first case %0d: got +%0d expected +1", k, (sync_q.size() > 0) ? sync_q[0] - t0 : -1);
      end
      for (int i = 1; i < sync_q.size(); i++) begin
        n_checks++;
        if (sync_q[i] - sync_q[i-1] !== sp) begin
          n_fail++;
          $display("FAIL cont_spacing case %0d p=%0d d=%0d l=%0d: got %0d expected %0d",
                   k, p, d, l, sync_q[i] - sync_q[i-1], sp);
        end
      end
      for (int i = 0; i < done_q.size() && i < sync_q.size(); i++) begin
        n_checks++;
        if (done_q[i] - sync_q[i] !== d + l + 2) begin
          n_fail++;
          $display("FAIL cont_done case %0d: got %0d expected %0d", k, done_q[i] - sync_q[i], d + l + 2);
        end
      end
      n_checks++;
      if (frameCount !== CW'(exp_count)) begin
        n_fail++;
        $display("FAIL cont_count case %0d: got %0d expected %0d", k, frameCount, exp_count);
      end
`ifdef ANTON_NEOPIXEL_SCHED_OVERRUN_EN
      exp_overrun = model_overrun(p, d, l) ? n - 1 : 0;
      n_checks++;
      if (overrunCount !== 8'(exp_overrun)) begin
        n_fail++;
        $display("FAIL cont_overrun case %0d: got %0d expected %0d", k, overrunCount, exp_overrun);
      end
`endif
    end
  endtask

  task automatic test_overrun();
    int t0;
    bit expired;
    enable = 1'b1;
    pulse_clear();
    run_frames(10, 0, 50, 4, t0, expired);
    exp_count += 4;
    n_checks++;
    if (expired || sync_q.size() !== 4 || done_q.size() !== 4) begin
      n_fail++;
      $display("FAIL overrun_pulses: got sync %0d done %0d expected 4", sync_q.size(), done_q.size());
    end
    for (int i = 1; i < sync_q.size() && i <= done_q.size(); i++) begin
      n_checks++;
      if (sync_q[i] !== done_q[i-1] + 1) begin
        n_fail++;
        $display("FAIL overrun_restart: got start %0d cycles after done expected 1", sync_q[i] - done_q[i-1]);
      end
    end
    n_checks++;
    if (frameCount !== CW'(exp_count)) begin
      n_fail++;
      $display("FAIL overrun_count: got %0d expected %0d", frameCount, exp_count);
    end
`ifdef ANTON_NEOPIXEL_SCHED_OVERRUN_EN
    n_checks++;
    if (overrunCount !== 8'd3) begin
      n_fail++;
      $display("FAIL overrun_counter: got %0d expected 3", overrunCount);
    end
    pulse_clear();
    n_checks++;
    if (overrunCount !== 8'd0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %0d expected 0", overrunCount);
    end
`endif
  endtask

  task automatic test_period_zero();
    int t0;
    bit expired;
    enable = 1'b1;
    for (int pp = 0; pp < 2; pp++) begin
      run_frames(pp, 1, 2, 4, t0, expired);
      exp_count += 4;
      n_checks++;
      if (expired || sync_q.size() !== 4) begin
        n_fail++;
        $display("FAIL period_small_pulses p=%0d: got %0d expected 4", pp, sync_q.size());
      end
      for (int i = 1; i < sync_q.size(); i++) begin
        n_checks++;
        if (sync_q[i] - sync_q[i-1] !== 6) begin
          n_fail++;
          $display("FAIL period_small_spacing p=%0d: got %0d expected 6", pp, sync_q[i] - sync_q[i-1]);
        end
      end
    end
    n_checks++;
    if (frameCount !== CW'(exp_count)) begin
      n_fail++;
      $display("FAIL period_small_count: got %0d expected %0d", frameCount, exp_count);
    end
  endtask

  task automatic test_timeout();
    int t;
    int s;
    int w;
    bit seen;
    xmit_en = 1'b0; enable = 1'b1; continuous = 1'b0;
    pulse_clear();
    sync_q.delete(); done_q.delete();
    pulse_trigger(t);
    s = t + 1;
    w = 0; seen = 1'b0;
    while (!seen && w < 200) begin
      if (timeoutErr === 1'b1) seen = 1'b1;
      else begin tick(1); w++; end
    end
    n_checks++;
    if (!seen || cyc !== s + TO + 1) begin
      n_fail++;
      $display("FAIL timeout_rise: got +%0d expected +%0d", seen ? cyc - s : -1, TO + 1);
    end
    n_checks++;
    if (schedBusy !== 1'b0 || frameCount !== CW'(exp_count) || done_q.size() !== 0) begin
      n_fail++;
      $display("FAIL timeout_state: got busy %b count %0d done %0d expected 0 / %0d / 0",
               schedBusy, frameCount, done_q.size(), exp_count);
    end
    pulse_clear();
    n_checks++;
    if (timeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b expected 0", timeoutErr);
    end
    pulse_trigger(t);
    tick(TO);
    errClear = 1'b1;
    tick(1);
    errClear = 1'b0;
    tick(3);
    n_checks++;
    if (timeoutErr !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_set_beats_clear: got %b expected 1", timeoutErr);
    end
    pulse_clear();
    xmit_en = 1'b1;
  endtask

  task automatic test_reset_mid_stream();
    int t;
    bit expired;
    enable = 1'b1; continuous = 1'b0;
    xmit_delay = 0; xmit_len = 40;
    sync_q.delete(); done_q.delete();
    pulse_trigger(t);
    tick(15);
    n_checks++;
    if (schedBusy !== 1'b1 || frameCount === '0) begin
      n_fail++;
      $display("FAIL midstream_pre: got busy %b count %0d expected 1 / nonzero", schedBusy, frameCount);
    end
    apbPresern = 1'b0;
    #1;
    n_checks++;
    if ({syncStart, frameDone, timeoutErr, schedBusy} !== 4'b0000 || frameCount !== '0) begin
      n_fail++;
      $display("FAIL midstream_reset: got flags %b count %0d expected 0000 / 0",
               {syncStart, frameDone, timeoutErr, schedBusy}, frameCount);
    end
    tick(3);
    apbPresern = 1'b1;
    exp_count = 0;
    wait_idle(expired);
    xmit_len = 12;
    sync_q.delete(); done_q.delete();
    pulse_trigger(t);
    wait_idle(expired);
    exp_count++;
    n_checks++;
    if (expired || sync_q.size() !== 1 || done_q.size() !== 1 ||
        (sync_q.size() > 0 && sync_q[0] !== t + 1) ||
        (done_q.size() > 0 && done_q[0] !== t + 15)) begin
      n_fail++;
      $display("FAIL midstream_restart: got sync %0d done %0d first done +%0d expected 1 / 1 / +15",
               sync_q.size(), done_q.size(), (done_q.size() > 0) ? done_q[0] - t : -1);
    end
    n_checks++;
    if (frameCount !== CW'(exp_count)) begin
      n_fail++;
      $display("FAIL midstream_count: got %0d expected %0d", frameCount, exp_count);
    end
  endtask

  task automatic test_trigger_during_stream();
    int t;
    int t2;
    bit expired;
    enable = 1'b1; continuous = 1'b0;
    xmit_delay = 0; xmit_len = 20;
    sync_q.delete(); done_q.delete();
    pulse_trigger(t);
    tick(8);
    pulse_trigger(t2);
    tick(2);
    pulse_trigger(t2);
    wait_idle(expired);
    exp_count += 2;
    n_checks++;
    if (expired || sync_q.size() !== 2 || done_q.size() !== 2) begin
      n_fail++;
      $display("FAIL stream_trigger_pulses: got sync %0d done %0d expected 2 / 2", sync_q.size(), done_q.size());
    end
    n_checks++;
    if (sync_q.size() < 2 || done_q.size() < 1 || sync_q[1] !== done_q[0] + 1) begin
      n_fail++;
      $display("FAIL stream_trigger_restart: got %0d expected 1",
               (sync_q.size() > 1 && done_q.size() > 0) ? sync_q[1] - done_q[0] : -1);
    end
    n_checks++;
    if (frameCount !== CW'(exp_count)) begin
      n_fail++;
      $display("FAIL stream_trigger_count: got %0d expected %0d", frameCount, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_pending_disabled();
    test_continuous();
    test_overrun();
    test_period_zero();
    test_timeout();
    test_trigger_during_stream();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_frame_scheduler.md
# anton_neopixel_frame_scheduler

Frame sequencer for the NeoPixel transmitter. It decides when each frame is streamed: it issues the `syncStart` pulse, either on a one-shot software trigger or periodically at a programmed refresh period. It then tracks the transmitter's busy indication to frame completion, and reports frames, timeouts and overruns. It sits beside the NeoPixel module in the `clk6_4mhz` domain, and its `syncStart` drives the module's `syncStart`.

## Interface
Parameters:
- `PERIOD_WIDTH`, 24: width of the refresh period counter (max period about 2.6 s at 6.4 MHz).
- `TIMEOUT`, 64: ticks allowed between `syncStart` and `streamBusy` rising.
- `COUNT_WIDTH`, 16: width of the frame counter.

Ports (all synchronous to `clk6_4mhz`; `streamBusy` is already in that domain):
- `clk6_4mhz`, in, 1: the single clock.
- `apbPresern`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: scheduler enable level.
- `continuous`, in, 1: 1 = periodic refresh; 0 = one-shot on `trigger`.
- `trigger`, in, 1: one-cycle request for a single frame.
- `period`, in, `PERIOD_WIDTH`: ticks from one `syncStart` to the next. A value of 0 is treated as 1.
- `streamBusy`, in, 1: high while the transmitter streams data or its reset delay.
- `errClear`, in, 1: one-cycle clear of `timeoutErr`.
- `syncStart`, out, 1: one-cycle frame start pulse.
- `frameDone`, out, 1: one-cycle pulse when a frame completes.
- `frameCount`, out, `COUNT_WIDTH`: completed frames. Wraps at 2^`COUNT_WIDTH`.
- `timeoutErr`, out, 1: sticky. Set when `streamBusy` never rose.
- `schedBusy`, out, 1: high in every state other than IDLE.

## Operation
The FSM has five states: IDLE, START, WAIT_BUSY, STREAM, WAIT_PERIOD. All outputs are registered.

- **Pending request:** `pending` is set by `trigger` in any state and cleared on entry to START. This gives one-deep queueing; extra triggers are dropped.
- **IDLE:**
  - Goes to START if `enable && (pending || trigger || continuous)`.
  - `trigger` with `enable=0` still sets `pending`, which is served when `enable` rises.
- **START:**
  - `syncStart=1` for this cycle only.
  - Resets the period counter and the timeout counter to 0.
  - Always goes to WAIT_BUSY.
- **WAIT_BUSY:**
  - `streamBusy=1` goes to STREAM.
  - If the timeout counter reaches `TIMEOUT-1` first: set `timeoutErr`, go to IDLE. There is no `frameDone` and no count increment.
- **STREAM:**
  - On the first cycle with `streamBusy=0`: pulse `frameDone`, increment `frameCount`.
  - Then go to WAIT_PERIOD if `enable && continuous`, else IDLE.
  - `enable` falling mid-stream never aborts; the frame completes first.
- **WAIT_PERIOD:**
  - Goes to START when period counter ≥ `max(period,1)-1`.
  - Goes to IDLE when `enable=0` or `continuous=0`, unless `pending` is set, in which case it goes to START.
- **Period counter:** increments every cycle after START and saturates at all-ones. A `period` change takes effect at the next comparison.
- **Overrun:** the counter reaches `period-1` while in WAIT_BUSY or STREAM. The next START then follows immediately after WAIT_PERIOD, so the frame rate degrades to the stream length.
- **Errors:**
  - `errClear` clears `timeoutErr`.
  - A simultaneous set and clear leaves the flag set.
- **Reset:**
  - `apbPresern` low at any time: FSM goes to IDLE, all counters and flags go to 0.
  - Every output is 0 during and after reset.
  - Reset mid-stream leaves the transmitter running; the scheduler restarts cleanly from IDLE.

## Timing
- **Trigger latency:** `trigger` sampled in IDLE at edge N gives `syncStart` high in cycle N+1 (after edge N+1) for exactly one cycle.
- **Frame completion:** `streamBusy` low sampled at edge M gives `frameDone` and the incremented `frameCount` visible after edge M+1.
- **Continuous spacing:** `syncStart` pulses are spaced exactly `max(period,1)+1` cycles apart whenever the stream finishes before the period expires (the extra cycle is START).
- **Timeout:** `timeoutErr` rises `TIMEOUT+1` cycles after `syncStart`.

## Configuration
- `ANTON_NEOPIXEL_SCHED_OVERRUN_EN` defined:
  - Adds output `overrunCount`, 8 bits, saturating at 255, incremented once per overrunning frame.
  - `errClear` also clears `overrunCount`.
- Undefined: no port, no counter; overrun behaviour is otherwise identical.

## Structure
- Shared package / `anton_common.vh` holds:
  - the FSM state encodings (3-bit localparams)
  - `SCHED_PERIOD_WIDTH_DEFAULT`
  - `SCHED_TIMEOUT_DEFAULT`
- Sub-module `anton_sched_period_counter`: saturating up-counter with clear and a `≥ period-1` compare output. It is reused for the timeout counter.

## Test plan
- **One-shot:** `continuous=0`, `enable=1`, `trigger` at cycle 10; `streamBusy` high cycles 13-40.
  - Expect `syncStart` high in cycle 11 only.
  - Expect `frameDone` pulse in cycle 42 and `frameCount=1`.
- **Continuous:** `period=100`, stream length 30.
  - Expect `syncStart` every 101 cycles.
  - Expect `frameCount=5` after 5 frames.
- **Overrun:** `period=10`, stream length 50.
  - Expect START on the cycle right after each WAIT_PERIOD entry.
  - Expect `overrunCount` to increment per frame when `ANTON_NEOPIXEL_SCHED_OVERRUN_EN` is defined.
- **Timeout:** `streamBusy` held 0 after `trigger`.
  - Expect `timeoutErr=1` 65 cycles after `syncStart`, FSM in IDLE, `frameCount` unchanged.
  - `errClear` returns `timeoutErr` to 0.
- **Reset mid-stream:** `apbPresern` low during STREAM.
  - Expect all outputs 0 immediately.
  - After release, `trigger` produces a normal frame.
- **Edge cases:**
  - `period=0` behaves as 1.
  - A `trigger` during STREAM with `continuous=0` yields exactly one extra `syncStart` after `frameDone`.
